pwm_gen_per: RTL and testbench

- Memory-mapped MSP430 peripheral that generates the PWM_out gating signal consumed by the ring-oscillator measurement peripheral.
- Supports programmable period, duty, output polarity, and a continuous or counted-burst mode.
- Sits on the per_* bus next to the RO peripheral; its pwm_out drives the RO block's PWM_out input directly.
- Gives software cycle-exact control over RO enable windows.

---
 rtl/pwm_gen_per.sv | 238 +++++++++++++++++++++++
 tb/tb_pwm_gen_per.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_gen_per.sv
// ============================================================================
// Module   : pwm_gen_per
// Purpose  : Memory-mapped PWM gate generator for the ring-oscillator block;
//            continuous or counted-burst mode with glitch-free shadowing.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pwm_gen_per #(
  parameter logic [14:0] BASE_ADDR = 15'h01B0,
  parameter int          DEC_WD    = 4
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  output logic        pwm_out,
  output logic        pwm_busy
);

  localparam logic [DEC_WD-1:0] OFS_CTRL   = DEC_WD'('h0);
  localparam logic [DEC_WD-1:0] OFS_PERIOD = DEC_WD'('h2);
  localparam logic [DEC_WD-1:0] OFS_DUTY   = DEC_WD'('h4);
  localparam logic [DEC_WD-1:0] OFS_BURSTN = DEC_WD'('h6);
  localparam logic [DEC_WD-1:0] OFS_STATUS = DEC_WD'('h8);
  localparam logic [DEC_WD-1:0] OFS_CNT    = DEC_WD'('hA);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic              reg_sel;
  logic              reg_wr;
  logic              reg_rd;
  logic [DEC_WD-1:0] reg_ofs;

  logic [0:0]  state_q,     state_d;
  logic [14:0] ctrl_q,      ctrl_d;
  logic        start_q,     start_d;
  logic [15:0] period_q,    period_d;
  logic [15:0] duty_q,      duty_d;
  logic [15:0] burstn_q,    burstn_d;
  logic        done_q,      done_d;
  logic [15:0] cnt_q,       cnt_d;
  logic [15:0] period_sh_q, period_sh_d;
  logic [15:0] duty_sh_q,   duty_sh_d;
  logic [15:0] pulses_q,    pulses_d;
  logic        pwm_q,       pwm_d;

  logic ctrl_en;
  logic ctrl_burst;
  logic ctrl_pol;
  logic wrap;
  logic run_entry;
  logic set_done;
  logic raw;

  // --------------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------------
  always_comb begin
    reg_sel = per_en & (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
    reg_ofs = {per_addr[DEC_WD-2:0], 1'b0};
    reg_wr  = reg_sel & (|per_we);
    reg_rd  = reg_sel & ~(|per_we);
  end

  assign ctrl_en    = ctrl_q[0];
  assign ctrl_burst = ctrl_q[1];
  assign ctrl_pol   = ctrl_q[2];

  // --------------------------------------------------------------------------
  // Software-visible registers; START is a one-cycle strobe, never stored
  // --------------------------------------------------------------------------
  always_comb begin
    ctrl_d   = ctrl_q;
    period_d = period_q;
    duty_d   = duty_q;
    burstn_d = burstn_q;
    start_d  = 1'b0;
    if (reg_wr) begin
      case (reg_ofs)
        OFS_CTRL: begin
          ctrl_d  = per_din[14:0];
          start_d = per_din[15];
        end
        OFS_PERIOD: period_d = per_din;
        OFS_DUTY:   duty_d   = per_din;
        OFS_BURSTN: burstn_d = per_din;
        default:    ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer: shadows load on entry and at every wrap so a period in flight
  // always finishes with the values it started with
  // --------------------------------------------------------------------------
  assign wrap = (cnt_q == period_sh_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    period_sh_d = period_sh_q;
    duty_sh_d   = duty_sh_q;
    pulses_d    = pulses_q;
    run_entry   = 1'b0;
    set_done    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = 16'd0;
        if (ctrl_en) begin
          if (!ctrl_burst) begin
            run_entry = 1'b1;
          end else if (start_q) begin
            if (burstn_q == 16'd0) begin
              set_done = 1'b1;
            end else begin
              run_entry = 1'b1;
            end
          end
        end
        if (run_entry) begin
          state_d     = ST_RUN;
          period_sh_d = period_q;
          duty_sh_d   = duty_q;
          pulses_d    = burstn_q;
        end
      end

      ST_RUN: begin
        if (!ctrl_en) begin
          state_d = ST_IDLE;
          cnt_d   = 16'd0;
        end else if (wrap) begin
          cnt_d       = 16'd0;
          period_sh_d = period_q;
          duty_sh_d   = duty_q;
          if (ctrl_burst) begin
            if (pulses_q <= 16'd1) begin
              state_d  = ST_IDLE;
              pulses_d = 16'd0;
              set_done = 1'b1;
            end else begin
              pulses_d = pulses_q - 16'd1;
            end
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // Hardware set takes priority over a same-cycle write-1-to-clear
  always_comb begin
    done_d = done_q;
    if (reg_wr && (reg_ofs == OFS_STATUS) && per_din[1]) begin
      done_d = 1'b0;
    end
    if (set_done) begin
      done_d = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Output stage
  // --------------------------------------------------------------------------
  always_comb begin
    raw   = (state_q == ST_RUN) && (cnt_q < duty_sh_q);
    pwm_d = raw ^ ctrl_pol;
  end

  assign pwm_out  = pwm_q;
  assign pwm_busy = (state_q == ST_RUN);

  // --------------------------------------------------------------------------
  // Read mux
  // --------------------------------------------------------------------------
  always_comb begin
    per_dout = 16'h0000;
    if (reg_rd) begin
      case (reg_ofs)
        OFS_CTRL:   per_dout = {1'b0, ctrl_q};
        OFS_PERIOD: per_dout = period_q;
        OFS_DUTY:   per_dout = duty_q;
        OFS_BURSTN: per_dout = burstn_q;
        OFS_STATUS: per_dout = {14'd0, done_q, (state_q == ST_RUN)};
        OFS_CNT:    per_dout = cnt_q;
        default:    per_dout = 16'h0000;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state_q     <= ST_IDLE;
      ctrl_q      <= 15'd0;
      start_q     <= 1'b0;
      period_q    <= 16'd0;
      duty_q      <= 16'd0;
      burstn_q    <= 16'd0;
      done_q      <= 1'b0;
      cnt_q       <= 16'd0;
      period_sh_q <= 16'd0;
      duty_sh_q   <= 16'd0;
      pulses_q    <= 16'd0;
      pwm_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      start_q     <= start_d;
      period_q    <= period_d;
      duty_q      <= duty_d;
      burstn_q    <= burstn_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
      period_sh_q <= period_sh_d;
      duty_sh_q   <= duty_sh_d;
      pulses_q    <= pulses_d;
      pwm_q       <= pwm_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pwm_gen_per.sv
// ============================================================================
// Module   : tb_pwm_gen_per
// Purpose  : Self-checking bench for pwm_gen_per; expected waveforms are built
//            period by period from PERIOD/DUTY/BURSTN/POL.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pwm_gen_per;

  localparam logic [14:0] BASE_ADDR  = 15'h01B0;
  localparam logic [3:0]  OFS_CTRL   = 4'h0;
  localparam logic [3:0]  OFS_PERIOD = 4'h2;
  localparam logic [3:0]  OFS_DUTY   = 4'h4;
  localparam logic [3:0]  OFS_BURSTN = 4'h6;
  localparam logic [3:0]  OFS_STATUS = 4'h8;
  localparam logic [3:0]  OFS_CNT    = 4'hA;

  logic        mclk;
  logic        puc_rst;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;
  logic        pwm_out;
  logic        pwm_busy;

  int checks = 0;
  int errors = 0;
  logic exp_q[$];

  pwm_gen_per #(.BASE_ADDR(BASE_ADDR), .DEC_WD(4)) dut (
    .mclk     (mclk),
    .puc_rst  (puc_rst),
    .per_addr (per_addr),
    .per_din  (per_din),
    .per_en   (per_en),
    .per_we   (per_we),
    .per_dout (per_dout),
    .pwm_out  (pwm_out),
    .pwm_busy (pwm_busy)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // One clock; every cycle compares pwm_out against the next expected level
  task automatic tick();
    logic e;
    @(posedge mclk);
    @(negedge mclk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pwm_out", {15'd0, pwm_out}, {15'd0, e});
    end
  endtask

  function automatic logic [13:0] waddr(input logic [3:0] off);
    return {BASE_ADDR[14:4], off[3:1]};
  endfunction

  task automatic wr(input logic [3:0] off, input logic [15:0] data);
    per_en   = 1'b1;
    per_we   = 2'($urandom_range(1, 3));
    per_addr = waddr(off);
    per_din  = data;
    tick();
    per_en   = 1'b0;
    per_we   = 2'b00;
    per_din  = 16'h0000;
  endtask

  task automatic chk_rd(input string tag, input logic [3:0] off, input logic [15:0] exp);
    logic [15:0] d;
    per_en   = 1'b1;
    per_we   = 2'b00;
    per_addr = waddr(off);
    #1;
    d = per_dout;
    per_en = 1'b0;
    chk(tag, d, exp);
  endtask

  // One period of the ideal waveform: high for the first D cycles, then low
  function automatic void push_period(input int p, input int d, input logic pol);
    for (int c = 0; c <= p; c++) exp_q.push_back(logic'(c < d) ^ pol);
  endfunction

  task automatic stop_run(input logic pol);
    wr(OFS_CTRL, {13'd0, pol, 2'b00});
    exp_q.delete();
    tick();
    chk("busy_after_stop", {15'd0, pwm_busy}, 16'd0);
    repeat (3) exp_q.push_back(pol);
    while (exp_q.size() > 0) tick();
  endtask

  task automatic run_burst(input int p, input int d, input int n, input logic pol);
    wr(OFS_PERIOD, 16'(p));
    wr(OFS_DUTY, 16'(d));
    wr(OFS_BURSTN, 16'(n));
    wr(OFS_CTRL, {13'h1000, pol, 2'b11});
    tick();
    chk("burst_busy_start", {15'd0, pwm_busy}, 16'd1);
    for (int i = 0; i < n; i++) push_period(p, d, pol);
    repeat (3) exp_q.push_back(pol);
    while (exp_q.size() > 0) tick();
    chk("burst_busy_end", {15'd0, pwm_busy}, 16'd0);
    chk_rd("burst_status_done", OFS_STATUS, 16'h0002);
    chk_rd("ctrl_readback", OFS_CTRL, {13'd0, pol, 2'b11});
    wr(OFS_STATUS, 16'h0002);
    chk_rd("status_cleared", OFS_STATUS, 16'h0000);
    wr(OFS_CTRL, {13'd0, pol, 2'b00});
    tick();
  endtask

  initial begin
    puc_rst  = 1'b1;
    per_en   = 1'b0;
    per_we   = 2'b00;
    per_addr = 14'd0;
    per_din  = 16'd0;
    tick();
    tick();
    chk("rst_pwm", {15'd0, pwm_out}, 16'd0);
    chk("rst_busy", {15'd0, pwm_busy}, 16'd0);
    chk_rd("rst_ctrl", OFS_CTRL, 16'd0);
    chk_rd("rst_status", OFS_STATUS, 16'd0);
    chk_rd("rst_cnt", OFS_CNT, 16'd0);
    puc_rst = 1'b0;
    tick();

    // Readback and decode miss
    wr(OFS_PERIOD, 16'h1234);
    chk_rd("period_rb", OFS_PERIOD, 16'h1234);
    per_en = 1'b1; per_we = 2'b00; per_addr = 14'h00D0 | 14'(OFS_PERIOD >> 1);
    #1;
    chk("decode_miss", per_dout, 16'h0000);
    per_en = 1'b0;

    // Reset in the middle of a run
    wr(OFS_PERIOD, 16'd9);
    wr(OFS_DUTY, 16'd3);
    wr(OFS_CTRL, 16'h0001);
    repeat (16) tick();
    puc_rst = 1'b1;
    tick();
    puc_rst = 1'b0;
    chk("midrst_pwm", {15'd0, pwm_out}, 16'd0);
    chk("midrst_busy", {15'd0, pwm_busy}, 16'd0);
    chk_rd("midrst_cnt", OFS_CNT, 16'd0);
    chk_rd("midrst_status", OFS_STATUS, 16'd0);
    chk_rd("midrst_ctrl", OFS_CTRL, 16'd0);
    chk_rd("midrst_period", OFS_PERIOD, 16'd0);

    // Continuous 3 high / 7 low, counter wraps 9 -> 0
    wr(OFS_PERIOD, 16'd9);
    wr(OFS_DUTY, 16'd3);
    wr(OFS_CTRL, 16'h0001);
    tick();
    chk("cont_busy", {15'd0, pwm_busy}, 16'd1);
    chk_rd("cont_cnt_entry", OFS_CNT, 16'd0);
    repeat (3) push_period(9, 3, 1'b0);
    for (int j = 0; j < 30; j++) begin
      tick();
      chk_rd("cont_cnt", OFS_CNT, 16'((j + 1) % 10));
    end
    stop_run(1'b0);

    // DUTY change mid-period only affects the following periods
    wr(OFS_CTRL, 16'h0001);
    tick();
    push_period(9, 3, 1'b0);
    push_period(9, 6, 1'b0);
    push_period(9, 6, 1'b0);
    tick();
    chk_rd("duty_chg_cnt", OFS_CNT, 16'd1);
    wr(OFS_DUTY, 16'd6);
    while (exp_q.size() > 0) tick();
    stop_run(1'b0);

    // Constant levels and polarity
    for (int pol = 0; pol < 2; pol++) begin
      for (int k = 0; k < 2; k++) begin
        wr(OFS_DUTY, (k == 0) ? 16'd0 : 16'd12);
        wr(OFS_CTRL, {13'd0, 1'(pol), 2'b01});
        tick();
        repeat (2) push_period(9, (k == 0) ? 0 : 12, 1'(pol));
        while (exp_q.size() > 0) tick();
        stop_run(1'(pol));
      end
    end
    wr(OFS_CTRL, 16'h0000);
    tick();

    // Directed and randomized bursts
    run_burst(4, 2, 4, 1'b0);
    for (int it = 0; it < 6; it++) begin
      int p;
      p = int'($urandom_range(0, 12));
      run_burst(p, int'($urandom_range(0, p + 2)), int'($urandom_range(1, 4)),
                1'($urandom_range(0, 1)));
    end

    // EN dropped during a burst: abort without DONE
    wr(OFS_PERIOD, 16'd4);
    wr(OFS_DUTY, 16'd2);
    wr(OFS_BURSTN, 16'd4);
    wr(OFS_CTRL, 16'h8007);
    tick();
    repeat (4) push_period(4, 2, 1'b1);
    tick();
    tick();
    chk_rd("abort_cnt", OFS_CNT, 16'd2);
    stop_run(1'b1);
    chk_rd("abort_status", OFS_STATUS, 16'h0000);

    // START with BURSTN = 0: DONE only, no pulse
    wr(OFS_BURSTN, 16'd0);
    wr(OFS_CTRL, 16'h8003);
    tick();
    chk("zero_burst_busy", {15'd0, pwm_busy}, 16'd0);
    chk_rd("zero_burst_status", OFS_STATUS, 16'h0002);
    repeat (4) exp_q.push_back(1'b0);
    while (exp_q.size() > 0) tick();
    wr(OFS_STATUS, 16'h0002);
    chk_rd("zero_burst_clr", OFS_STATUS, 16'h0000);
    wr(OFS_CTRL, 16'h0000);

    // DONE set and write-1-to-clear on the same edge: set wins
    wr(OFS_PERIOD, 16'd2);
    wr(OFS_DUTY, 16'd1);
    wr(OFS_BURSTN, 16'd2);
    wr(OFS_CTRL, 16'h8003);
    tick();
    repeat (2) push_period(2, 1, 1'b0);
    repeat (2) exp_q.push_back(1'b0);
    repeat (5) tick();
    wr(OFS_STATUS, 16'h0002);
    chk_rd("done_set_wins", OFS_STATUS, 16'h0002);
    while (exp_q.size() > 0) tick();
    wr(OFS_STATUS, 16'h0002);
    chk_rd("done_final_clr", OFS_STATUS, 16'h0000);
    wr(OFS_CTRL, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
